// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg: shared types, header constants and sizing helper for the Ethernet header prepender
package eth_tx_pkg;

    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, PAD, GAP} state_t;

    localparam int HDR_BITS = 112;

    localparam logic [47:0] DEF_DST_MAC   = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] DEF_SRC_MAC   = 48'h6969_5A06_5490;
    localparam logic [15:0] DEF_ETHERTYPE = 16'h0101;

    // Payload counter must hold the pad target and any realistic frame without wrapping
    function automatic int pay_cnt_width(input int minu, input int depth);
        int m;
        m = (minu > depth + 65536) ? minu : depth + 65536;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/eth_header_tx_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with occupancy output
module sync_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty = cnt_q == '0;
    assign full  = cnt_q == LW'(DEPTH);
    assign level = cnt_q;
    assign dout  = mem_q[rd_q];

    // Pointer and occupancy update; simultaneous push and pop leaves occupancy unchanged
    always_comb begin
        do_push = push && (!full || pop);
        do_pop  = pop && !empty;
        wr_d    = do_push ? ((wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
        rd_d    = do_pop ? ((rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
        cnt_d   = cnt_q + LW'(do_push) - LW'(do_pop);
    end

    // Control state, flushed by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array, no reset needed since occupancy gates reads
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/eth_header_tx.sv
// eth_header_tx: prepends MAC/ethertype header, pads payload to minimum length, enforces inter-frame gap
module eth_header_tx
    import eth_tx_pkg::*;
#(
    parameter int          W                 = 2,
    parameter logic [47:0] DST_MAC           = DEF_DST_MAC,
    parameter logic [47:0] SRC_MAC           = DEF_SRC_MAC,
    parameter logic [15:0] ETHERTYPE         = DEF_ETHERTYPE,
    parameter int          MIN_PAYLOAD_BYTES = 46,
    parameter int          FIFO_DEPTH        = 64,
    parameter int          IFG_CYCLES        = 48
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         axiiv,
    input  logic [W-1:0] axiid,
    output logic         axiov,
    output logic [W-1:0] axiod,
    output logic         busy,
    output logic         err_drop
);
    localparam int HC   = HDR_BITS / W;
    localparam int MINU = MIN_PAYLOAD_BYTES * 8 / W;
    localparam int BPB  = 8 / W;
    localparam int PCW  = pay_cnt_width(MINU, FIFO_DEPTH);
    localparam int HCW  = $clog2(HC + 1);
    localparam int GCW  = $clog2(IFG_CYCLES + 1);
    localparam int LW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [HDR_BITS-1:0] HDR_VEC = {DST_MAC, SRC_MAC, ETHERTYPE};

    if (FIFO_DEPTH < HC + 2) begin : g_depth_chk
        $error("eth_header_tx: FIFO_DEPTH must be at least 112/W + 2");
    end

    state_t         state_q, state_d;
    logic           in_open_q, in_open_d;
    logic [HCW-1:0] hdr_cnt_q, hdr_cnt_d;
    logic [PCW-1:0] pay_cnt_q, pay_cnt_d, pay_nx;
    logic [GCW-1:0] gap_cnt_q, gap_cnt_d;
    logic           axiov_q, axiov_d, err_drop_q, err_drop_d;
    logic [W-1:0]   axiod_q, axiod_d, hdr_beat, fifo_dout;
    logic           push, pop, fifo_empty, fifo_full, drained, pad_ok;
    logic [LW-1:0]  fifo_level;

    sync_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (axiid),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    assign axiov    = axiov_q;
    assign axiod    = axiod_q;
    assign err_drop = err_drop_q;
    assign busy     = state_q != IDLE;

    // State register and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            in_open_q  <= 1'b0;
            hdr_cnt_q  <= '0;
            pay_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            axiov_q    <= 1'b0;
            axiod_q    <= '0;
            err_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_open_q  <= in_open_d;
            hdr_cnt_q  <= hdr_cnt_d;
            pay_cnt_q  <= pay_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            axiov_q    <= axiov_d;
            axiod_q    <= axiod_d;
            err_drop_q <= err_drop_d;
        end
    end

    // Next-state: frame closes on the first idle input cycle, payload exit uses the post-pop FIFO occupancy
    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        pay_cnt_d = pay_cnt_q;
        gap_cnt_d = gap_cnt_q;
        in_open_d = (state_q == IDLE) ? axiiv : (in_open_q && axiiv);
        pay_nx    = (&pay_cnt_q) ? pay_cnt_q : pay_cnt_q + 1'b1;
        pad_ok    = (pay_nx >= PCW'(MINU)) && ((pay_nx & PCW'(BPB - 1)) == '0);
        drained   = (fifo_level <= LW'(1)) && !push;
        case (state_q)
            IDLE: if (axiiv) begin
                state_d   = HDR;
                hdr_cnt_d = HCW'(1);
                pay_cnt_d = '0;
                gap_cnt_d = '0;
            end
            HDR: begin
                hdr_cnt_d = (hdr_cnt_q == HCW'(HC - 1)) ? '0 : hdr_cnt_q + 1'b1;
                state_d   = (hdr_cnt_q == HCW'(HC - 1)) ? PAYLOAD : HDR;
            end
            PAYLOAD: begin
                pay_cnt_d = pay_nx;
                if (drained && !in_open_d) state_d = pad_ok ? GAP : PAD;
            end
            PAD: begin
                pay_cnt_d = pay_nx;
                if (pad_ok) state_d = GAP;
            end
            GAP: begin
                gap_cnt_d = (gap_cnt_q == GCW'(IFG_CYCLES - 1)) ? '0 : gap_cnt_q + 1'b1;
                pay_cnt_d = '0;
                state_d   = (gap_cnt_q == GCW'(IFG_CYCLES - 1)) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and FIFO strobes: header beat index is the current header count (0 while idle)
    always_comb begin
        hdr_beat   = W'(HDR_VEC >> (HDR_BITS - W * (int'(hdr_cnt_q) + 1)));
        push       = axiiv && !fifo_full &&
                     ((state_q == IDLE) || (in_open_q && (state_q == HDR || state_q == PAYLOAD)));
        pop        = (state_q == PAYLOAD) && !fifo_empty;
        err_drop_d = axiiv && (state_q != IDLE) && !in_open_q;
        axiov_d    = (state_q == IDLE) ? axiiv : (state_q != GAP);
        axiod_d    = ((state_q == IDLE && axiiv) || state_q == HDR) ? hdr_beat :
                     (state_q == PAYLOAD) ? fifo_dout : '0;
    end

endmodule

// File: tb/tb_eth_header_tx.sv
// tb_eth_header_tx: frame-level model check of W=2 and W=8 instances plus literal header/length checks
module tb_eth_header_tx;
    logic       clk = 1'b0, rst = 1'b0;
    logic       v2 = 1'b0, v8 = 1'b0;
    logic [1:0] d2 = '0;
    logic [7:0] d8 = '0;
    logic       ov2, b2, e2, ov8, b8, e8;
    logic [1:0] od2;
    logic [7:0] od8;

    int tests = 0, fails = 0;
    int wd[2] = '{2, 8};
    int mode[2], k[2], len[2], open_m[2], flen[2], g[2];
    int pay[2][0:1023];
    int ev[2], ed[2], ee[2], eb[2];
    int hi[2], lo[2], last_hi[2], last_lo[2], prev[2], drops[2];
    int cap[2][0:511];
    logic [7:0] buf_b[0:63];

    always #10 clk = ~clk;

    eth_header_tx #(.W(2)) dut2 (
        .clk(clk), .rst(rst), .axiiv(v2), .axiid(d2),
        .axiov(ov2), .axiod(od2), .busy(b2), .err_drop(e2)
    );

    eth_header_tx #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .axiiv(v8), .axiid(d8),
        .axiov(ov8), .axiod(od8), .busy(b8), .err_drop(e8)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int hdr_beat(input int w, input int idx);
        logic [111:0] h;
        logic [7:0]   top;
        h   = {48'hFFFF_FFFF_FFFF, 48'h6969_5A06_5490, 16'h0101};
        h   = h << (w * idx);
        top = h[111:104];
        return int'(top >> (8 - w));
    endfunction

    // Frame-level model: output index k walks header, payload, zero pad up to the rounded minimum, then the gap
    task automatic step(input int i, input int v, input int d);
        int w, hc, minu, bpb, n;
        w = wd[i]; hc = 112 / w; minu = 368 / w; bpb = 8 / w;
        ee[i] = 0; ev[i] = 0; ed[i] = 0;
        if (mode[i] == 0) begin
            if (v != 0) begin
                mode[i] = 1; k[i] = 0; len[i] = 1; pay[i][0] = d; open_m[i] = 1;
                ev[i] = 1; ed[i] = hdr_beat(w, 0);
            end
        end else if (mode[i] == 1) begin
            k[i]++;
            if (open_m[i] != 0 && v != 0) begin
                if (len[i] < 1024) pay[i][len[i]] = d;
                len[i]++;
            end else if (open_m[i] != 0) begin
                open_m[i] = 0;
                n = (len[i] > minu) ? len[i] : minu;
                flen[i] = hc + ((n + bpb - 1) / bpb) * bpb;
            end else if (v != 0) ee[i] = 1;
            if (open_m[i] == 0 && k[i] >= flen[i]) begin
                mode[i] = 2; g[i] = 1;
            end else begin
                ev[i] = 1;
                ed[i] = (k[i] < hc) ? hdr_beat(w, k[i]) :
                        (k[i] - hc < len[i]) ? pay[i][k[i] - hc] : 0;
            end
        end else begin
            if (v != 0) ee[i] = 1;
            g[i]++;
            if (g[i] >= 48) mode[i] = 0;
        end
        eb[i] = (mode[i] != 0) ? 1 : 0;
    endtask

    task automatic rec(input int i, input int v, input int d, input int e);
        if (v != 0) begin
            if (prev[i] == 0) begin last_lo[i] = lo[i]; hi[i] = 0; end
            if (hi[i] < 512) cap[i][hi[i]] = d;
            hi[i]++;
        end else begin
            if (prev[i] != 0) begin last_hi[i] = hi[i]; lo[i] = 0; end
            lo[i]++;
        end
        prev[i] = v;
        drops[i] += e;
    endtask

    // Single compare process: advance the model on each edge, check every DUT output 1 time unit later
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin mode[i] = 0; prev[i] = 0; hi[i] = 0; lo[i] = 0; end
        end else begin
            step(0, int'(v2), int'(d2));
            step(1, int'(v8), int'(d8));
        end
        #1;
        if (!rst) begin
            chk("w2_axiov", int'(ov2), ev[0]);
            chk("w2_axiod", int'(od2), ed[0]);
            chk("w2_err_drop", int'(e2), ee[0]);
            chk("w2_busy", int'(b2), eb[0]);
            chk("w8_axiov", int'(ov8), ev[1]);
            chk("w8_axiod", int'(od8), ed[1]);
            chk("w8_err_drop", int'(e8), ee[1]);
            chk("w8_busy", int'(b8), eb[1]);
            rec(0, int'(ov2), int'(od2), int'(e2));
            rec(1, int'(ov8), int'(od8), int'(e8));
        end
    end

    task automatic send2(input int nbytes);
        for (int j = 0; j < nbytes; j++)
            for (int b = 3; b >= 0; b--) begin
                v2 = 1'b1; d2 = buf_b[j][2*b +: 2];
                @(negedge clk);
            end
        v2 = 1'b0; d2 = '0;
    endtask

    task automatic send8(input int nbytes);
        for (int j = 0; j < nbytes; j++) begin
            v8 = 1'b1; d8 = buf_b[j];
            @(negedge clk);
        end
        v8 = 1'b0; d8 = '0;
    endtask

    task automatic wait_idle(input int i);
        int c = 0;
        while (((i == 0) ? (b2 | ov2) : (b8 | ov8)) && c < 3000) begin @(negedge clk); c++; end
        chk("idle_wait", int'(c < 3000), 1);
    endtask

    task automatic wait_ov_low2();
        int c = 0;
        while (ov2 && c < 3000) begin @(negedge clk); c++; end
        chk("ov_low_wait", int'(c < 3000), 1);
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_axiov", int'(ov2), 0);
        chk("rst_axiod", int'(od2), 0);
        chk("rst_busy", int'(b2), 0);
        chk("rst_err_drop", int'(e2), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 4-byte payload DEADBEEF: header, payload, pad to 46 bytes
        buf_b[0] = 8'hDE; buf_b[1] = 8'hAD; buf_b[2] = 8'hBE; buf_b[3] = 8'hEF;
        fork
            send2(4);
            begin
                @(posedge clk); #2;
                chk("latency_axiov", int'(ov2), 1);
                chk("latency_axiod", int'(od2), 3);
            end
        join
        wait_idle(0);
        chk("a_len", last_hi[0], 240);
        chk("a_dst0", cap[0][0], 3);
        chk("a_dst23", cap[0][23], 3);
        chk("a_src0", cap[0][24], 1);
        chk("a_src1", cap[0][25], 2);
        chk("a_type0", cap[0][48], 0);
        chk("a_type7", cap[0][55], 1);
        chk("a_pay0", cap[0][56], 3);
        chk("a_pay1", cap[0][57], 1);
        chk("a_pay15", cap[0][71], 3);
        chk("a_pad0", cap[0][72], 0);

        // 60-byte payload back to back: no pad, gap measured between frames
        for (int j = 0; j < 60; j++) buf_b[j] = 8'(j * 7 + 3);
        send2(60);
        wait_idle(0);
        chk("b_gap", last_lo[0], 48);
        chk("b_len", last_hi[0], 296);
        chk("b_pay0", cap[0][56], 0);
        chk("b_pay3", cap[0][59], 3);

        // beats offered during PAD and GAP are dropped
        buf_b[0] = 8'h12; buf_b[1] = 8'h34; buf_b[2] = 8'h56; buf_b[3] = 8'h78;
        drops[0] = 0;
        send2(4);
        repeat (60) @(negedge clk);
        for (int j = 0; j < 5; j++) begin v2 = 1'b1; d2 = 2'(j); @(negedge clk); end
        v2 = 1'b0;
        wait_ov_low2();
        for (int j = 0; j < 3; j++) begin v2 = 1'b1; d2 = 2'(j + 1); @(negedge clk); end
        v2 = 1'b0;
        wait_idle(0);
        chk("c_drops", drops[0], 8);
        chk("c_len", last_hi[0], 240);
        send2(4);
        wait_idle(0);
        chk("d_len", last_hi[0], 240);
        chk("d_drops", drops[0], 8);

        // one-cycle input drop mid-frame: frame ends there, returning beats dropped
        drops[0] = 0;
        for (int j = 0; j < 10; j++) begin v2 = 1'b1; d2 = 2'($urandom_range(0, 3)); @(negedge clk); end
        v2 = 1'b0; @(negedge clk);
        for (int j = 0; j < 6; j++) begin v2 = 1'b1; d2 = 2'($urandom_range(0, 3)); @(negedge clk); end
        v2 = 1'b0;
        wait_idle(0);
        chk("e_drops", drops[0], 6);
        chk("e_len", last_hi[0], 240);

        // reset while header beat 10 is on the output
        v2 = 1'b1; d2 = 2'b10;
        repeat (11) @(negedge clk);
        chk("f_pre_rst_axiov", int'(ov2), 1);
        rst = 1'b1; v2 = 1'b0;
        #1;
        chk("f_rst_axiov", int'(ov2), 0);
        chk("f_rst_busy", int'(b2), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send2(4);
        wait_idle(0);
        chk("g_first", cap[0][0], 3);
        chk("g_len", last_hi[0], 240);

        // W=8, 50-byte payload: 14 header bytes, no pad
        for (int j = 0; j < 50; j++) buf_b[j] = 8'(8'hA0 + j);
        send8(50);
        wait_idle(1);
        chk("h_len", last_hi[1], 64);
        chk("h_dst0", cap[1][0], 255);
        chk("h_type0", cap[1][12], 1);
        chk("h_type1", cap[1][13], 1);
        chk("h_pay0", cap[1][14], 8'hA0);
        chk("h_pay49", cap[1][63], 8'hA0 + 49);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
